// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and reset values for the FIFO pointer controller
package fifo_pkg;

    localparam int   RST_PTR   = 0;
    localparam logic RST_WRAP  = 1'b0;
    localparam logic RST_PULSE = 1'b0;

    // Occupancy needs one extra bit so that a completely full FIFO (count == DEPTH) is representable
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - modulo-DEPTH address counter with wrap bit and carry-out
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] adr,
    output logic              wrap,
    output logic              cout
);

    logic at_end;

    assign at_end = (adr == ADDR_W'(DEPTH - 1));
    assign cout   = inc & at_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr  <= ADDR_W'(RST_PTR);
            wrap <= RST_WRAP;
        end else if (clr) begin
            adr  <= ADDR_W'(RST_PTR);
            wrap <= RST_WRAP;
        end else if (inc) begin
            // Wrap bit distinguishes full from empty when both addresses coincide
            if (at_end) begin
                adr  <= '0;
                wrap <= ~wrap;
            end else begin
                adr  <= adr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer/flag controller; FIFO_PTR_SCLR_EN adds synchronous clr
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef FIFO_PTR_SCLR_EN
    input  logic                       clr,
`endif
    input  logic                       push,
    input  logic                       pop,
    output logic                       push_ok,
    output logic                       pop_ok,
    output logic [ADDR_W-1:0]          wr_adr,
    output logic [ADDR_W-1:0]          rd_adr,
    output logic [cnt_w(ADDR_W)-1:0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       ovf,
    output logic                       udf
);

    localparam int CW = cnt_w(ADDR_W);

    logic clr_i;
    logic wr_wrap, rd_wrap;
    logic wr_cout, rd_cout;
    logic adr_eq;

`ifdef FIFO_PTR_SCLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign adr_eq = (wr_adr == rd_adr);
    assign full   = adr_eq & (wr_wrap != rd_wrap);
    assign empty  = adr_eq & (wr_wrap == rd_wrap);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push alongside it
    assign pop_ok  = pop & ~empty & ~clr_i;
    assign push_ok = push & (~full | pop_ok) & ~clr_i;

    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

    fifo_ptr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_i),
        .inc   (push_ok),
        .adr   (wr_adr),
        .wrap  (wr_wrap),
        .cout  (wr_cout)
    );

    fifo_ptr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_i),
        .inc   (pop_ok),
        .adr   (rd_adr),
        .wrap  (rd_wrap),
        .cout  (rd_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ovf   <= RST_PULSE;
            udf   <= RST_PULSE;
        end else if (clr_i) begin
            count <= '0;
            ovf   <= RST_PULSE;
            udf   <= RST_PULSE;
        end else begin
            ovf <= push & ~push_ok;
            udf <= pop & ~pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_flags_match_count: assert property (@(posedge clk) disable iff (!reset)
        (full == (count == CW'(DEPTH))) && (empty == (count == '0)));

    a_wr_wraps_to_zero: assert property (@(posedge clk) disable iff (!reset || clr_i)
        wr_cout |=> (wr_adr == '0));

    a_rd_wraps_to_zero: assert property (@(posedge clk) disable iff (!reset || clr_i)
        rd_cout |=> (rd_adr == '0));

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - table-driven check of fifo_ptr_ctrl at DEPTH 8 and DEPTH 6
module tb_fifo_ptr_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic push_a = 1'b0, pop_a = 1'b0, push_b = 1'b0, pop_b = 1'b0;
`ifdef FIFO_PTR_SCLR_EN
    logic clr_a = 1'b0, clr_b = 1'b0;
`endif

    logic       pok_a, qok_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [2:0] wr_a, rd_a;
    logic [3:0] cnt_a;
    logic       pok_b, qok_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [2:0] wr_b, rd_b;
    logic [3:0] cnt_b;

    fifo_ptr_ctrl #(.ADDR_W(3), .DEPTH(8), .AF_LVL(6), .AE_LVL(1)) dut_a (
        .clk(clk), .reset(reset),
`ifdef FIFO_PTR_SCLR_EN
        .clr(clr_a),
`endif
        .push(push_a), .pop(pop_a), .push_ok(pok_a), .pop_ok(qok_a),
        .wr_adr(wr_a), .rd_adr(rd_a), .count(cnt_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .ovf(ovf_a), .udf(udf_a)
    );

    fifo_ptr_ctrl #(.ADDR_W(3), .DEPTH(6), .AF_LVL(4), .AE_LVL(2)) dut_b (
        .clk(clk), .reset(reset),
`ifdef FIFO_PTR_SCLR_EN
        .clr(clr_b),
`endif
        .push(push_b), .pop(pop_b), .push_ok(pok_b), .pop_ok(qok_b),
        .wr_adr(wr_b), .rd_adr(rd_b), .count(cnt_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .ovf(ovf_b), .udf(udf_b)
    );

    typedef struct {
        int         dut;
        logic       push, pop, epush, epop;
        logic [2:0] wr, rd;
        logic [3:0] cnt;
        logic       ovf, udf;
    } vec_t;

    vec_t vecs[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int d, input logic pu, input logic po, input logic ep, input logic eo,
                       input int w, input int r, input int c, input logic ov, input logic ud);
        vecs.push_back('{d, pu, po, ep, eo, 3'(w), 3'(r), 4'(c), ov, ud});
    endtask

    // Flags follow from the expected count and each instance's depth/levels
    task automatic check_state(input int d, input int w, input int r, input int c,
                               input logic ov, input logic ud, input string tag);
        int dep = (d == 0) ? 8 : 6;
        int afl = (d == 0) ? 6 : 4;
        int ael = (d == 0) ? 1 : 2;
        chk({tag, ".wr_adr"}, 8'(d == 0 ? wr_a : wr_b), 8'(w));
        chk({tag, ".rd_adr"}, 8'(d == 0 ? rd_a : rd_b), 8'(r));
        chk({tag, ".count"},  8'(d == 0 ? cnt_a : cnt_b), 8'(c));
        chk({tag, ".full"},   8'(d == 0 ? full_a : full_b), 8'(c == dep));
        chk({tag, ".empty"},  8'(d == 0 ? empty_a : empty_b), 8'(c == 0));
        chk({tag, ".almost_full"},  8'(d == 0 ? af_a : af_b), 8'(c >= afl));
        chk({tag, ".almost_empty"}, 8'(d == 0 ? ae_a : ae_b), 8'(c <= ael));
        chk({tag, ".ovf"}, 8'(d == 0 ? ovf_a : ovf_b), 8'(ov));
        chk({tag, ".udf"}, 8'(d == 0 ? udf_a : udf_b), 8'(ud));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        push_a = (v.dut == 0) ? v.push : 1'b0;
        pop_a  = (v.dut == 0) ? v.pop  : 1'b0;
        push_b = (v.dut == 1) ? v.push : 1'b0;
        pop_b  = (v.dut == 1) ? v.pop  : 1'b0;
        #1;
        chk({tag, ".push_ok"}, 8'(v.dut == 0 ? pok_a : pok_b), 8'(v.epush));
        chk({tag, ".pop_ok"},  8'(v.dut == 0 ? qok_a : qok_b), 8'(v.epop));
        @(posedge clk);
        #1;
        check_state(v.dut, int'(v.wr), int'(v.rd), int'(v.cnt), v.ovf, v.udf, tag);
    endtask

    initial begin
        // DEPTH 8: fill, overflow, pass-through when full, drain, underflow
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 1, 0, i % 8, 0, i, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 8, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 8, 0, 0);
        add(0, 1, 1, 1, 1, 1, 1, 8, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 1, 1, (1 + k) % 8, 8 - k, 0, 0);
        add(0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 2, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        // DEPTH 6: non-power-of-two wrap on both pointers
        for (int i = 1; i <= 6; i++) add(1, 1, 0, 1, 0, i % 6, 0, i, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 6, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 6, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1, 6, 0, 0);
        for (int k = 1; k <= 6; k++) add(1, 0, 1, 0, 1, 1, (1 + k) % 6, 6 - k, 0, 0);
        add(1, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        add(1, 1, 1, 1, 0, 2, 1, 1, 0, 1);

        #11;
        check_state(0, 0, 0, 0, 0, 0, "rst_a");
        check_state(1, 0, 0, 0, 0, 0, "rst_b");
        #1.5;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Three pushes, then reset asserted between edges must clear outputs immediately
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_a = 1'b1; pop_a = 1'b0; push_b = 1'b0; pop_b = 1'b0;
        end
        @(negedge clk);
        push_a = 1'b0;
        #1;
        check_state(0, 5, 1, 4, 0, 0, "pre_arst");
        #1;
        reset = 1'b0;
        #1;
        check_state(0, 0, 0, 0, 0, 0, "arst_a");
        check_state(1, 0, 0, 0, 0, 0, "arst_b");
        @(negedge clk);
        reset = 1'b1;

`ifdef FIFO_PTR_SCLR_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_a = 1'b1;
        end
        @(negedge clk);
        clr_a = 1'b1;
        #1;
        chk("clr.push_ok", 8'(pok_a), 8'd0);
        check_state(0, 5, 0, 5, 0, 0, "pre_clr");
        @(posedge clk);
        #1;
        check_state(0, 0, 0, 0, 0, 0, "clr");
        @(negedge clk);
        clr_a  = 1'b0;
        push_a = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
